// File: rtl/board_state_tracker.sv
// Per-cell play state, revealed/flag counters and win/loss resolution for the mining board.
// Optional build macro AUTO_FLAG_ON_WIN_EN: on a win, flag every remaining hidden cell before WON.
module board_state_tracker #(
    parameter int MAX_DIM = 16,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       button_num,
    input  logic [5:0]       mines,
    input  logic [4:0]       button_ind_x,
    input  logic [4:0]       button_ind_y,
    input  logic             explode,
    input  logic             defuse,
    input  logic             mark_flag,
    input  logic [4:0]       rd_x,
    input  logic [4:0]       rd_y,
    output logic [1:0]       rd_cell,
    output logic [CNT_W-1:0] revealed_count,
    output logic [CNT_W-1:0] flag_count,
    output logic             busy,
    output logic             game_won,
    output logic             game_lost
);
    localparam int CELLS = MAX_DIM * MAX_DIM;
    localparam int AW    = $clog2(CELLS);

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        REVEALED = 2'd1,
        FLAGGED  = 2'd2,
        EXPLODED = 2'd3
    } cell_t;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_PLAY,
        S_WON,
        S_LOST
`ifdef AUTO_FLAG_ON_WIN_EN
        , S_AUTOFLAG
`endif
    } state_t;

    state_t          state, state_next;
    logic [1:0]      cells [CELLS];
    logic [AW-1:0]   sweep_addr;
    logic [AW-1:0]   ev_addr, rd_addr, waddr;
    logic [1:0]      ev_cell, wdata;
    logic [CNT_W-1:0] win_target;
    logic            ev_ok, we;
    logic            rev_inc, flag_inc, flag_dec, set_won, set_lost;

    assign ev_addr = AW'(int'(button_ind_y) * MAX_DIM + int'(button_ind_x));
    assign rd_addr = AW'(int'(rd_y) * MAX_DIM + int'(rd_x));
    assign ev_cell = cells[ev_addr];
    assign ev_ok   = (button_ind_x < button_num) && (button_ind_y < button_num) &&
                     (int'(button_ind_x) < MAX_DIM) && (int'(button_ind_y) < MAX_DIM);
    assign win_target = CNT_W'(button_num) * CNT_W'(button_num) - CNT_W'(mines);

`ifdef AUTO_FLAG_ON_WIN_EN
    logic [4:0]    af_x, af_y;
    logic [AW-1:0] af_addr;
    logic [1:0]    af_cell;
    logic          af_last;

    assign af_addr = AW'(int'(af_y) * MAX_DIM + int'(af_x));
    assign af_cell = cells[af_addr];
    assign af_last = (af_x == button_num - 5'd1) && (af_y == button_num - 5'd1);
    assign busy    = (state == S_CLEAR) || (state == S_AUTOFLAG);

    // Row-major walk over the active board; restarts whenever the sweep is not running.
    always_ff @(posedge clk) begin
        if (!rst || state != S_AUTOFLAG) begin
            af_x <= '0;
            af_y <= '0;
        end else if (af_x == button_num - 5'd1) begin
            af_x <= '0;
            af_y <= af_y + 5'd1;
        end else begin
            af_x <= af_x + 5'd1;
        end
    end
`else
    assign busy = (state == S_CLEAR);
`endif

    always_comb begin
        state_next = state;
        we         = 1'b0;
        waddr      = ev_addr;
        wdata      = HIDDEN;
        rev_inc    = 1'b0;
        flag_inc   = 1'b0;
        flag_dec   = 1'b0;
        set_won    = 1'b0;
        set_lost   = 1'b0;
        if (start) begin
            state_next = S_CLEAR;
        end else begin
            case (state)
                S_CLEAR: begin
                    we    = 1'b1;
                    waddr = sweep_addr;
                    if (sweep_addr == AW'(CELLS - 1)) state_next = S_PLAY;
                end
                S_PLAY: begin
                    if (ev_ok && explode) begin
                        we         = 1'b1;
                        wdata      = EXPLODED;
                        flag_dec   = (ev_cell == FLAGGED);
                        set_lost   = 1'b1;
                        state_next = S_LOST;
                    end else begin
                        if (ev_ok && defuse) begin
                            if (ev_cell == HIDDEN) begin
                                we      = 1'b1;
                                wdata   = REVEALED;
                                rev_inc = 1'b1;
                            end
                        end else if (ev_ok && mark_flag) begin
                            if (ev_cell == FLAGGED) begin
                                we       = 1'b1;
                                wdata    = HIDDEN;
                                flag_dec = 1'b1;
                            end else if (ev_cell == HIDDEN && flag_count < CNT_W'(mines)) begin
                                we       = 1'b1;
                                wdata    = FLAGGED;
                                flag_inc = 1'b1;
                            end
                        end
                        // Compare uses the registered count, so a win lands one cycle after the last reveal.
                        if (revealed_count == win_target) begin
`ifdef AUTO_FLAG_ON_WIN_EN
                            state_next = S_AUTOFLAG;
`else
                            set_won    = 1'b1;
                            state_next = S_WON;
`endif
                        end
                    end
                end
`ifdef AUTO_FLAG_ON_WIN_EN
                S_AUTOFLAG: begin
                    waddr    = af_addr;
                    wdata    = FLAGGED;
                    we       = (af_cell == HIDDEN);
                    flag_inc = (af_cell == HIDDEN);
                    if (af_last) begin
                        set_won    = 1'b1;
                        state_next = S_WON;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && we) cells[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_CLEAR;
            sweep_addr     <= '0;
            revealed_count <= '0;
            flag_count     <= '0;
            game_won       <= 1'b0;
            game_lost      <= 1'b0;
            rd_cell        <= '0;
        end else begin
            state   <= state_next;
            rd_cell <= cells[rd_addr];
            if (start) begin
                sweep_addr     <= '0;
                revealed_count <= '0;
                flag_count     <= '0;
                game_won       <= 1'b0;
                game_lost      <= 1'b0;
            end else begin
                if (state == S_CLEAR) sweep_addr <= sweep_addr + AW'(1);
                if (rev_inc) revealed_count <= revealed_count + CNT_W'(1);
                if (flag_inc) flag_count <= flag_count + CNT_W'(1);
                else if (flag_dec) flag_count <= flag_count - CNT_W'(1);
                if (set_won) game_won <= 1'b1;
                if (set_lost) game_lost <= 1'b1;
            end
        end
    end

    // Counters must never wrap in either direction.
    always_ff @(posedge clk) begin
        if (rst && !start) begin
            assert (!(flag_dec && flag_count == '0));
            assert (!(flag_inc && flag_count == '1));
            assert (!(rev_inc && revealed_count == '1));
        end
    end

endmodule

// File: tb/tb_board_state_tracker.sv
// Directed bench for board_state_tracker: board-array model checked every cycle plus literal checkpoints.
module tb_board_state_tracker;
    logic       clk = 1'b0;
    logic       rst, start, explode, defuse, mark_flag;
    logic [4:0] button_num, bx, by, rd_x, rd_y;
    logic [5:0] mines;
    logic [1:0] rd_cell;
    logic [8:0] revealed_count, flag_count;
    logic       busy, game_won, game_lost;

    always #5 clk = ~clk;

    board_state_tracker #(.MAX_DIM(16), .CNT_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .button_num(button_num), .mines(mines),
        .button_ind_x(bx), .button_ind_y(by), .explode(explode), .defuse(defuse),
        .mark_flag(mark_flag), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
        .revealed_count(revealed_count), .flag_count(flag_count), .busy(busy),
        .game_won(game_won), .game_lost(game_lost)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Game model: phases of play, a 16x16 board of cell codes, counts derived from the board.
    localparam int P_CLEAR = 0, P_PLAY = 1, P_WON = 2, P_LOST = 3, P_AF = 4;
    int mb [16][16];
    int phase, clear_left, af_left, m_won, m_lost, rd_exp;
    bit rd_chk, m_valid;

    function automatic int count_state(input int v);
        int c = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (mb[y][x] == v) c++;
        return c;
    endfunction

    task automatic clear_board();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                mb[y][x] = 0;
    endtask

    task automatic model_step();
        int n, pre_rev, target, x, y, idx;
        bit lost_now;
        if (!rst) begin
            clear_board();
            phase = P_CLEAR; clear_left = 256; m_won = 0; m_lost = 0;
            rd_chk = 1; rd_exp = 0; m_valid = 1;
            return;
        end
        rd_chk = (phase != P_CLEAR);
        if (rd_chk) rd_exp = mb[rd_y][rd_x];
        if (start) begin
            clear_board();
            phase = P_CLEAR; clear_left = 256; m_won = 0; m_lost = 0;
            return;
        end
        n = int'(button_num);
        case (phase)
            P_CLEAR: begin
                clear_left--;
                if (clear_left == 0) phase = P_PLAY;
            end
            P_PLAY: begin
                pre_rev  = count_state(1);
                target   = (n * n - int'(mines)) & 511;
                lost_now = 0;
                x = int'(bx); y = int'(by);
                if (x < n && y < n && x < 16 && y < 16) begin
                    if (explode) begin
                        mb[y][x] = 3; lost_now = 1;
                    end else if (defuse) begin
                        if (mb[y][x] == 0) mb[y][x] = 1;
                    end else if (mark_flag) begin
                        if (mb[y][x] == 2) mb[y][x] = 0;
                        else if (mb[y][x] == 0 && count_state(2) < int'(mines)) mb[y][x] = 2;
                    end
                end
                if (lost_now) begin
                    phase = P_LOST; m_lost = 1;
                end else if (pre_rev == target) begin
`ifdef AUTO_FLAG_ON_WIN_EN
                    phase = P_AF; af_left = n * n;
`else
                    phase = P_WON; m_won = 1;
`endif
                end
            end
            P_AF: begin
                idx = n * n - af_left;
                x = idx % n; y = idx / n;
                if (mb[y][x] == 0) mb[y][x] = 2;
                af_left--;
                if (af_left == 0) begin
                    phase = P_WON; m_won = 1;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        m_valid = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("busy", int'(busy), (phase == P_CLEAR || phase == P_AF) ? 1 : 0);
                chk("revealed_count", int'(revealed_count), count_state(1));
                chk("flag_count", int'(flag_count), count_state(2));
                chk("game_won", int'(game_won), m_won);
                chk("game_lost", int'(game_lost), m_lost);
                if (rd_chk) chk("rd_cell", int'(rd_cell), rd_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ev(input logic [2:0] kind, input int x, input int y);
        bx = 5'(x); by = 5'(y);
        {explode, defuse, mark_flag} = kind;
        @(negedge clk);
        {explode, defuse, mark_flag} = 3'b000;
    endtask

    task automatic set_rd(input int x, input int y);
        rd_x = 5'(x); rd_y = 5'(y);
    endtask

    task automatic wait_idle(input string name, input int exp_cycles);
        int cyc = 0;
        while (busy && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, cyc, exp_cycles);
    endtask

    task automatic read_sweep();
        for (int i = 0; i < 256; i++) begin
            set_rd(i % 16, i / 16);
            tick();
        end
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    localparam logic [2:0] K_EXP = 3'b100, K_DEF = 3'b010, K_FLG = 3'b001;

    initial begin
        rst = 1'b0; start = 1'b0; button_num = 5'd8; mines = 6'd10;
        bx = '0; by = '0; explode = 1'b0; defuse = 1'b0; mark_flag = 1'b0;
        rd_x = '0; rd_y = '0;
        repeat (3) tick();
        chk("reset_busy", int'(busy), 1);
        chk("reset_revealed", int'(revealed_count), 0);
        chk("reset_flags", int'(flag_count), 0);
        chk("reset_rd_cell", int'(rd_cell), 0);
        chk("reset_won_lost", int'({game_won, game_lost}), 0);
        rst = 1'b1;
        wait_idle("clear_len_after_reset", 256);
        read_sweep();

        // Repeated defuse of one cell counts once.
        set_rd(3, 4);
        ev(K_DEF, 3, 4);
        ev(K_DEF, 3, 4);
        tick();
        chk("defuse_twice_rd", int'(rd_cell), 1);
        chk("defuse_twice_count", int'(revealed_count), 1);

        // Flag toggle; defuse on a flag is ignored.
        set_rd(1, 1);
        ev(K_FLG, 1, 1); tick();
        chk("flag_on_rd", int'(rd_cell), 2);
        chk("flag_on_count", int'(flag_count), 1);
        ev(K_DEF, 1, 1); tick();
        chk("defuse_on_flag_rd", int'(rd_cell), 2);
        ev(K_FLG, 1, 1); tick();
        chk("flag_off_rd", int'(rd_cell), 0);
        chk("flag_off_count", int'(flag_count), 0);

        // Eleven flags against ten mines.
        for (int i = 0; i < 11; i++)
            ev(K_FLG, (i < 8) ? i : i - 8, (i < 8) ? 7 : 6);
        set_rd(2, 6);
        tick(); tick();
        chk("flag_saturate_count", int'(flag_count), 10);
        chk("flag_saturate_rd", int'(rd_cell), 0);

        // Simultaneous explode+defuse: explode wins.
        set_rd(2, 2);
        ev(K_EXP | K_DEF, 2, 2);
        tick();
        chk("explode_rd", int'(rd_cell), 3);
        chk("explode_lost", int'(game_lost), 1);
        ev(K_DEF, 5, 5);
        chk("lost_frozen_revealed", int'(revealed_count), 1);
        pulse_start();
        chk("start_busy", int'(busy), 1);
        chk("start_lost_cleared", int'(game_lost), 0);
        chk("start_flags_cleared", int'(flag_count), 0);
        wait_idle("clear_len_after_start", 256);
        read_sweep();
        set_rd(2, 2); tick(); tick();
        chk("cleared_rd_2_2", int'(rd_cell), 0);

        // Out-of-range event, then a full winning game.
        ev(K_DEF, 9, 0);
        chk("out_of_range_ignored", int'(revealed_count), 0);
        for (int i = 0; i < 54; i++)
            ev(K_DEF, i % 8, i / 8);
        chk("win_revealed", int'(revealed_count), 54);
        chk("win_not_yet", int'(game_won), 0);
        tick();
`ifdef AUTO_FLAG_ON_WIN_EN
        chk("autoflag_busy", int'(busy), 1);
        wait_idle("autoflag_len", 64);
        chk("autoflag_won", int'(game_won), 1);
        chk("autoflag_flags", int'(flag_count), 10);
`else
        chk("win_rises", int'(game_won), 1);
        chk("win_flags_untouched", int'(flag_count), 0);
`endif
        ev(K_DEF, 7, 7);
        chk("won_frozen_revealed", int'(revealed_count), 54);

        // Reset in the middle of a clear sweep.
        pulse_start();
        repeat (100) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midclear_reset_busy", int'(busy), 1);
        chk("midclear_reset_counts", int'(revealed_count) + int'(flag_count), 0);
        chk("midclear_reset_won", int'(game_won), 0);
        wait_idle("clear_len_after_midreset", 256);

        // Exploding a flagged cell releases its flag.
        set_rd(4, 4);
        ev(K_FLG, 4, 4);
        chk("preexplode_flag", int'(flag_count), 1);
        ev(K_EXP, 4, 4);
        tick();
        chk("explode_flagged_count", int'(flag_count), 0);
        chk("explode_flagged_rd", int'(rd_cell), 3);
        chk("explode_flagged_lost", int'(game_lost), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
